// File: rtl/sram_like_pkg.sv
// Shared constants, encodings and the response-entry type for the SRAM-like slave.
package sram_like_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_RSVD = 2'd3
  } sram_size_e;

  typedef struct packed {
    logic              wr;
    logic [WAIT_W-1:0] wait_cnt;
    logic              data_valid;
    logic [DATA_W-1:0] data;
  } sram_like_entry_t;

  // Saturating decrement used by the per-entry response countdown.
  function automatic logic [WAIT_W-1:0] wait_dec(input logic [WAIT_W-1:0] w);
    return (w == {WAIT_W{1'b0}}) ? w : w - WAIT_W'(1);
  endfunction

endpackage

// File: rtl/sram_like_resp_fifo.sv
// In-order response buffer: circular queue of outstanding requests, each with its own
// delay countdown, plus a capture port that fills an entry one cycle after it was pushed.
module sram_like_resp_fifo
  import sram_like_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int DATA_DELAY = 0,
  parameter int PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              push_wr,
  input  logic              cap_en,
  input  logic [PTR_W-1:0]  cap_idx,
  input  logic [DATA_W-1:0] cap_data,
  output logic [PTR_W-1:0]  tail_ptr,
  output logic [CNT_W-1:0]  count,
  output logic              head_ready,
  output logic [DATA_W-1:0] head_data
);

  localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(DEPTH - 1);
  localparam logic [WAIT_W-1:0] DELAY_INIT = WAIT_W'(DATA_DELAY);

  sram_like_entry_t entries [DEPTH];
  sram_like_entry_t head_e;
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  logic             head_cap;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  // A head entry being captured this cycle may answer straight from the capture data
  always_comb begin
    head_e     = entries[head_r];
    head_cap   = cap_en && (cap_idx == head_r);
    head_ready = (count_r != {CNT_W{1'b0}}) && (head_e.wait_cnt == {WAIT_W{1'b0}}) &&
                 (head_e.data_valid || head_cap);
    if (head_e.data_valid) begin
      head_data = head_e.data;
    end else if (head_e.wr) begin
      head_data = {DATA_W{1'b0}};
    end else begin
      head_data = cap_data;
    end
    pop      = head_ready;
    tail_ptr = tail_r;
    count    = count_r;
  end

  // Entry storage: countdown, capture and push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (entries[i].data_valid) begin
          entries[i].wait_cnt <= wait_dec(entries[i].wait_cnt);
        end
      end
      // The capture cycle itself counts as the first countdown step.
      if (cap_en) begin
        entries[cap_idx].data_valid <= 1'b1;
        entries[cap_idx].wait_cnt   <= wait_dec(entries[cap_idx].wait_cnt);
        entries[cap_idx].data       <= entries[cap_idx].wr ? {DATA_W{1'b0}} : cap_data;
      end
      if (push) begin
        entries[tail_r].wr         <= push_wr;
        entries[tail_r].wait_cnt   <= DELAY_INIT;
        entries[tail_r].data_valid <= 1'b0;
        entries[tail_r].data       <= {DATA_W{1'b0}};
      end
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (push) begin
        tail_r <= ptr_inc(tail_r);
      end
      if (pop) begin
        head_r <= ptr_inc(head_r);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/sram_like_responder.sv
// Slave end of the SRAM-like bus: accepts requests, issues them to a 1-cycle RAM and
// returns one in-order data_ok per accepted request after DATA_DELAY extra cycles.
module sram_like_responder
  import sram_like_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int DATA_DELAY = 0,
  parameter int RAM_AW     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sram_req,
  input  logic              sram_wr,
  input  logic [1:0]        sram_size,
  input  logic [ADDR_W-1:0] sram_addr,
  input  logic [STRB_W-1:0] sram_wstrb,
  input  logic [DATA_W-1:0] sram_wdata,
  output logic              sram_addr_ok,
  output logic              sram_data_ok,
  output logic [DATA_W-1:0] sram_rdata,
  input  logic              cfg_addr_stall,
  output logic              ram_en,
  output logic [STRB_W-1:0] ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic              accept;
  logic [PTR_W-1:0]  tail_ptr;
  logic [CNT_W-1:0]  count;
  logic              head_ready;
  logic [DATA_W-1:0] head_data;
  logic              cap_en_r;
  logic [PTR_W-1:0]  cap_idx_r;
  logic              unused_bits;

  // Size and byte offset travel with the request but the RAM only sees word addresses.
  assign unused_bits = ^{sram_size, sram_addr};

  // Acceptance, RAM drive and response presentation
  always_comb begin
    sram_addr_ok = !rst && !cfg_addr_stall && (count < DEPTH_C);
    accept       = sram_req && sram_addr_ok;
    ram_en       = accept;
    ram_we       = (accept && sram_wr) ? sram_wstrb : {STRB_W{1'b0}};
    ram_addr     = sram_addr[RAM_AW+1:2];
    ram_wdata    = sram_wdata;
    sram_data_ok = head_ready;
    sram_rdata   = head_ready ? head_data : {DATA_W{1'b0}};
  end

  // Remember which slot the RAM result of this cycle's accept belongs to
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_en_r  <= 1'b0;
      cap_idx_r <= {PTR_W{1'b0}};
    end else begin
      cap_en_r  <= accept;
      cap_idx_r <= tail_ptr;
    end
  end

  sram_like_resp_fifo #(
    .DEPTH      (DEPTH),
    .DATA_DELAY (DATA_DELAY),
    .PTR_W      (PTR_W),
    .CNT_W      (CNT_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (accept),
    .push_wr    (sram_wr),
    .cap_en     (cap_en_r),
    .cap_idx    (cap_idx_r),
    .cap_data   (ram_rdata),
    .tail_ptr   (tail_ptr),
    .count      (count),
    .head_ready (head_ready),
    .head_data  (head_data)
  );

endmodule

// File: tb/tb_sram_like_responder.sv
// Bench: two responders (DEPTH 2; DATA_DELAY 0 and 3) on shared stimulus, each checked
// cycle by cycle against a transaction model (response cycle = max(accept+1+D, prev+1)).
`timescale 1ns/1ps
module tb_sram_like_responder;

  localparam int N     = 2;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_req;
  logic        req, wr, stall;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;

  logic        aok    [N];
  logic        dok    [N];
  logic [31:0] rdata  [N];
  logic        ren    [N];
  logic [3:0]  rwe    [N];
  logic [15:0] raddr  [N];
  logic [31:0] rwdata [N];
  logic [31:0] rrdata [N];

  logic [31:0] env_mem [N][256];
  logic [31:0] ref_mem [N][256];
  int          q_resp  [N][$];
  logic [31:0] q_data  [N][$];
  int          last_resp    [N];
  logic [31:0] last_rdata   [N];
  int          last_dok_cyc [N];
  int          cyc, checks, failures, acc_cyc;

  always #5 clk = ~clk;

  sram_like_responder #(.DEPTH(DEPTH), .DATA_DELAY(0), .RAM_AW(16)) u_d0 (
    .clk(clk), .rst(rst), .sram_req(req), .sram_wr(wr), .sram_size(size),
    .sram_addr(addr), .sram_wstrb(wstrb), .sram_wdata(wdata),
    .sram_addr_ok(aok[0]), .sram_data_ok(dok[0]), .sram_rdata(rdata[0]),
    .cfg_addr_stall(stall), .ram_en(ren[0]), .ram_we(rwe[0]), .ram_addr(raddr[0]),
    .ram_wdata(rwdata[0]), .ram_rdata(rrdata[0])
  );

  sram_like_responder #(.DEPTH(DEPTH), .DATA_DELAY(3), .RAM_AW(16)) u_d3 (
    .clk(clk), .rst(rst), .sram_req(req), .sram_wr(wr), .sram_size(size),
    .sram_addr(addr), .sram_wstrb(wstrb), .sram_wdata(wdata),
    .sram_addr_ok(aok[1]), .sram_data_ok(dok[1]), .sram_rdata(rdata[1]),
    .cfg_addr_stall(stall), .ram_en(ren[1]), .ram_we(rwe[1]), .ram_addr(raddr[1]),
    .ram_wdata(rwdata[1]), .ram_rdata(rrdata[1])
  );

  function automatic int dly(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  function automatic logic [31:0] init_word(input int w);
    if (w == 32'h40) return 32'hDEADBEEF;
    if (w == 32'h80) return 32'hAAAAAAAA;
    return 32'h5A5A_0000 ^ 32'(w * 7919);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  // Environment RAM: one-cycle synchronous read, byte-lane writes
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (init_req) begin
        for (int w = 0; w < 256; w++) env_mem[i][w] <= init_word(w);
      end else if (ren[i]) begin
        rrdata[i] <= env_mem[i][raddr[i][7:0]];
        env_mem[i][raddr[i][7:0]] <= merge(env_mem[i][raddr[i][7:0]], rwdata[i], rwe[i]);
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Compare every DUT output for this cycle against the model, then advance the model.
  task automatic evaluate();
    logic        exp_aok, exp_dok, acc;
    logic [31:0] exp_rd;
    int          word, resp;
    for (int i = 0; i < N; i++) begin
      exp_aok = !rst && !stall && (q_resp[i].size() < DEPTH);
      exp_dok = !rst && (q_resp[i].size() > 0) && (q_resp[i][0] == cyc);
      exp_rd  = exp_dok ? q_data[i][0] : 32'h0;
      acc     = req && exp_aok;
      check_val($sformatf("d%0d_addr_ok", i), {31'h0, aok[i]}, {31'h0, exp_aok});
      check_val($sformatf("d%0d_data_ok", i), {31'h0, dok[i]}, {31'h0, exp_dok});
      check_val($sformatf("d%0d_rdata", i), rdata[i], exp_rd);
      check_val($sformatf("d%0d_ram_en", i), {31'h0, ren[i]}, {31'h0, acc});
      check_val($sformatf("d%0d_ram_we", i), {28'h0, rwe[i]},
                {28'h0, (acc && wr) ? wstrb : 4'h0});
      if (acc) begin
        check_val($sformatf("d%0d_ram_addr", i), {16'h0, raddr[i]}, {16'h0, addr[17:2]});
        if (wr) check_val($sformatf("d%0d_ram_wdata", i), rwdata[i], wdata);
      end
      if (dok[i] === 1'b1) begin
        last_rdata[i]   = rdata[i];
        last_dok_cyc[i] = cyc;
      end
      if (rst) begin
        q_resp[i].delete();
        q_data[i].delete();
        last_resp[i] = cyc;
      end else begin
        if (exp_dok) begin
          void'(q_resp[i].pop_front());
          void'(q_data[i].pop_front());
        end
        if (acc) begin
          word = int'(addr[9:2]);
          if (wr) begin
            ref_mem[i][word] = merge(ref_mem[i][word], wdata, wstrb);
            q_data[i].push_back(32'h0);
          end else begin
            q_data[i].push_back(ref_mem[i][word]);
          end
          resp = cyc + 1 + dly(i);
          if (last_resp[i] + 1 > resp) resp = last_resp[i] + 1;
          q_resp[i].push_back(resp);
          last_resp[i] = resp;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input logic st);
    req = r; wr = w; addr = a; wstrb = s; wdata = d; stall = st; size = 2'd2;
    @(negedge clk);
    evaluate();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
  endtask

  initial begin
    int w;
    checks = 0; failures = 0; cyc = 0;
    rst = 1'b1; init_req = 1'b1;
    req = 1'b0; wr = 1'b0; addr = 32'h0; wstrb = 4'h0; wdata = 32'h0; stall = 1'b0; size = 2'd2;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 256; k++) ref_mem[i][k] = init_word(k);
      last_resp[i] = -10; last_dok_cyc[i] = -1; last_rdata[i] = 32'h0;
    end
    @(posedge clk); #1;
    // Reset state, with a request pending to show acceptance is blocked
    step(1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    init_req = 1'b0;
    rst = 1'b0;

    // Single read of the preloaded word: latency 1 + D for both instances
    acc_cyc = cyc;
    step(1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 1'b0);
    idle(6);
    for (int i = 0; i < N; i++) begin
      check_val($sformatf("d%0d_first_rdata", i), last_rdata[i], 32'hDEADBEEF);
      check_val($sformatf("d%0d_first_latency", i), last_dok_cyc[i], acc_cyc + 1 + dly(i));
    end

    // Request held for 8 cycles: D=3 instance fills and back-pressures
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 32'h104 + 32'(4 * (k % 3)), 4'h0, 32'h0, 1'b0);
    idle(10);

    // Partial write then read of the same word
    step(1'b1, 1'b1, 32'h200, 4'b0011, 32'h12345678, 1'b0);
    step(1'b1, 1'b0, 32'h200, 4'h0, 32'h0, 1'b0);
    idle(8);
    for (int i = 0; i < N; i++) begin
      check_val($sformatf("d%0d_merged_rdata", i), last_rdata[i], 32'hAAAA5678);
    end

    // One read outstanding, then 4 stalled cycles with req held
    step(1'b1, 1'b0, 32'h108, 4'h0, 32'h0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 32'h10C, 4'h0, 32'h0, 1'b1);
    idle(4);

    // Asynchronous reset with two reads outstanding
    step(1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h104, 4'h0, 32'h0, 1'b0);
    req = 1'b0;
    rst = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      check_val($sformatf("d%0d_rst_data_ok", i), {31'h0, dok[i]}, 32'h0);
      check_val($sformatf("d%0d_rst_addr_ok", i), {31'h0, aok[i]}, 32'h0);
    end
    step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    rst = 1'b0;
    acc_cyc = cyc;
    step(1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 1'b0);
    idle(6);
    for (int i = 0; i < N; i++) begin
      check_val($sformatf("d%0d_post_rst_latency", i), last_dok_cyc[i], acc_cyc + 1 + dly(i));
    end

    // Randomized traffic with occasional stalls and reset pulses
    for (int k = 0; k < 600; k++) begin
      w = ($urandom_range(0, 2) == 0) ? 32'h80 + $urandom_range(0, 3) : 32'h40 + $urandom_range(0, 7);
      rst = ($urandom_range(0, 199) == 0);
      step($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0,
           32'((w << 2) | $urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 7) == 0);
    end
    rst = 1'b0;
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
